// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared types and constants for the iterative divider
//
// Purpose: FSM state encoding and iteration constants used by iter_divider.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // One quotient bit per BUSY cycle; the count after the last bit doubles as
  // the result-registration cycle.
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 6;

endpackage

// File: rtl/iter_divider_div_step.sv
// rtl/iter_divider_div_step.sv - one combinational radix-2 restoring divide step
//
// Purpose: shift the partial remainder left by one, bring in the next dividend
//          bit, trial-subtract the divisor and keep the difference if it is
//          non-negative.
// Ports:
//   rem_in   partial remainder before this step (always < divisor)
//   dvd_bit  next dividend bit, MSB first
//   divisor  divisor magnitude
//   rem_out  partial remainder after this step
//   q_bit    quotient bit produced by this step
module iter_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    // One extra bit of headroom: a borrow always lands in bit WIDTH because
    // shifted < 2*divisor, so the MSB is the sign of the trial difference.
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle 32-bit integer divider (DIV/MOD, signed and unsigned)
//
// Purpose: responder end of the execute-stage divide handshake. Produces
//          quotient and remainder together after a fixed 33-cycle latency.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   is_flush   abort current operation / drop completed result
//   is_stall   downstream not ready; hold the completed result
//   en         start request (sampled in IDLE only)
//   is_signed  1 = signed operands, 0 = unsigned
//   dividend   rj operand, sampled on the start cycle
//   divisor    rkd operand, sampled on the start cycle
//   quotient   registered quotient, valid while done=1
//   remainder  registered remainder, valid while done=1
//   done       result valid
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_flush,
  input  logic             is_stall,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS);

  div_state_t state, state_next;

  logic [CNT_W-1:0] counter;
  // Holds the dividend magnitude; quotient bits shift in from the bottom as
  // dividend bits leave the top, so after 32 steps it is the raw quotient.
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] raw_dvd;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  assign dvd_abs = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign dsr_abs = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

  iter_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (work[WIDTH-1]),
    .divisor (div_mag),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (en && !is_flush) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (is_flush) begin
          state_next = IDLE;
        end else if (counter == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (is_flush || !is_stall) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    done = (state == DONE);
  end

  // Datapath: operand capture, iteration, and result registration
  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      work      <= '0;
      rem_q     <= '0;
      div_mag   <= '0;
      raw_dvd   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !is_flush) begin
            work     <= dvd_abs;
            div_mag  <= dsr_abs;
            raw_dvd  <= dividend;
            q_neg    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg    <= is_signed && dividend[WIDTH-1];
            div_zero <= (divisor == '0);
            rem_q    <= '0;
            counter  <= '0;
          end
        end
        BUSY: begin
          if (!is_flush) begin
            if (counter != LAST_CNT) begin
              work    <= {work[WIDTH-2:0], q_bit};
              rem_q   <= rem_next;
              counter <= counter + 1'b1;
            end else if (div_zero) begin
              quotient  <= '1;
              remainder <= raw_dvd;
            end else begin
              // Signed overflow (INT_MIN / -1) needs no special case: the
              // unsigned quotient 0x80000000 with q_neg=0 is already correct.
              quotient  <= q_neg ? (~work + 1'b1) : work;
              remainder <= r_neg ? (~rem_q + 1'b1) : rem_q;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - directed self-checking bench for iter_divider
module tb_iter_divider;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             is_flush;
  logic             is_stall;
  logic             en;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  iter_divider #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .is_flush  (is_flush),
    .is_stall  (is_stall),
    .en        (en),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Start one divide and wait (bounded) for done; cyc is edges after the start edge.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int cyc);
    @(negedge clk);
    en = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk); #1;
    en = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'h0000_0003;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    q = quotient;
    r = remainder;
  endtask

  task automatic test_reset();
    rst = 1'b1; is_flush = 1'b0; is_stall = 1'b0; en = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else pass_cnt++;
    total_cnt++; if (quotient !== 32'h0) $display("FAIL reset_quot got=%h exp=00000000", quotient); else pass_cnt++;
    total_cnt++; if (remainder !== 32'h0) $display("FAIL reset_rem got=%h exp=00000000", remainder); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r;
    int cyc;
    run_div(1'b0, 32'd100, 32'd7, q, r, cyc);
    total_cnt++; if (cyc !== 33) $display("FAIL u_latency got=%0d exp=33", cyc); else pass_cnt++;
    total_cnt++; if (q !== 32'd14) $display("FAIL u_100_7_quot got=%h exp=0000000e", q); else pass_cnt++;
    total_cnt++; if (r !== 32'd2) $display("FAIL u_100_7_rem got=%h exp=00000002", r); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL u_done_drop got=%0b exp=0", done); else pass_cnt++;
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, q, r, cyc);
    total_cnt++; if (q !== 32'h0FFFFFFF) $display("FAIL u_max_quot got=%h exp=0fffffff", q); else pass_cnt++;
    total_cnt++; if (r !== 32'h0000000F) $display("FAIL u_max_rem got=%h exp=0000000f", r); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    logic [31:0] q, r;
    int cyc;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, q, r, cyc);
    total_cnt++; if (q !== 32'hFFFFFFFD) $display("FAIL s_m7_2_quot got=%h exp=fffffffd", q); else pass_cnt++;
    total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL s_m7_2_rem got=%h exp=ffffffff", r); else pass_cnt++;
    @(posedge clk); #1;
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, q, r, cyc);
    total_cnt++; if (q !== 32'hFFFFFFFD) $display("FAIL s_7_m2_quot got=%h exp=fffffffd", q); else pass_cnt++;
    total_cnt++; if (r !== 32'd1) $display("FAIL s_7_m2_rem got=%h exp=00000001", r); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_special();
    logic [31:0] q, r;
    int cyc;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, q, r, cyc);
    total_cnt++; if (q !== 32'h80000000) $display("FAIL ovf_quot got=%h exp=80000000", q); else pass_cnt++;
    total_cnt++; if (r !== 32'h0) $display("FAIL ovf_rem got=%h exp=00000000", r); else pass_cnt++;
    @(posedge clk); #1;
    run_div(1'b1, 32'h12345678, 32'h0, q, r, cyc);
    total_cnt++; if (cyc !== 33) $display("FAIL dz_s_latency got=%0d exp=33", cyc); else pass_cnt++;
    total_cnt++; if (q !== 32'hFFFFFFFF) $display("FAIL dz_s_quot got=%h exp=ffffffff", q); else pass_cnt++;
    total_cnt++; if (r !== 32'h12345678) $display("FAIL dz_s_rem got=%h exp=12345678", r); else pass_cnt++;
    @(posedge clk); #1;
    run_div(1'b0, 32'h12345678, 32'h0, q, r, cyc);
    total_cnt++; if (q !== 32'hFFFFFFFF) $display("FAIL dz_u_quot got=%h exp=ffffffff", q); else pass_cnt++;
    total_cnt++; if (r !== 32'h12345678) $display("FAIL dz_u_rem got=%h exp=12345678", r); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall_hold();
    logic [31:0] q, r;
    int cyc;
    is_stall = 1'b1;
    run_div(1'b0, 32'd1000, 32'd7, q, r, cyc);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      total_cnt++; if (done !== 1'b1) $display("FAIL stall_done[%0d] got=%0b exp=1", i, done); else pass_cnt++;
      total_cnt++; if (quotient !== 32'd142) $display("FAIL stall_quot[%0d] got=%h exp=0000008e", i, quotient); else pass_cnt++;
      total_cnt++; if (remainder !== 32'd6) $display("FAIL stall_rem[%0d] got=%h exp=00000006", i, remainder); else pass_cnt++;
    end
    is_stall = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL stall_release got=%0b exp=0", done); else pass_cnt++;
    run_div(1'b0, 32'd9, 32'd3, q, r, cyc);
    total_cnt++; if (q !== 32'd3) $display("FAIL after_stall_quot got=%h exp=00000003", q); else pass_cnt++;
    total_cnt++; if (r !== 32'd0) $display("FAIL after_stall_rem got=%h exp=00000000", r); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [31:0] q, r;
    int cyc;
    logic seen;
    @(negedge clk);
    en = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd3;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    is_flush = 1'b1;
    @(posedge clk); #1;
    is_flush = 1'b0;
    total_cnt++; if (done !== 1'b0) $display("FAIL flush_done got=%0b exp=0", done); else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL flush_no_done got=%0b exp=0", seen); else pass_cnt++;
    run_div(1'b0, 32'd50, 32'd5, q, r, cyc);
    total_cnt++; if (cyc !== 33) $display("FAIL post_flush_latency got=%0d exp=33", cyc); else pass_cnt++;
    total_cnt++; if (q !== 32'd10) $display("FAIL post_flush_quot got=%h exp=0000000a", q); else pass_cnt++;
    total_cnt++; if (r !== 32'd0) $display("FAIL post_flush_rem got=%h exp=00000000", r); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic seen;
    @(negedge clk);
    en = 1'b1; is_signed = 1'b1; dividend = 32'hFFFF0000; divisor = 32'd3;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++; if (done !== 1'b0) $display("FAIL midrst_done got=%0b exp=0", done); else pass_cnt++;
    total_cnt++; if (quotient !== 32'h0) $display("FAIL midrst_quot got=%h exp=00000000", quotient); else pass_cnt++;
    total_cnt++; if (remainder !== 32'h0) $display("FAIL midrst_rem got=%h exp=00000000", remainder); else pass_cnt++;
    @(negedge clk);
    en = 1'b1; is_flush = 1'b1; is_signed = 1'b0; dividend = 32'd40; divisor = 32'd4;
    @(posedge clk); #1;
    en = 1'b0; is_flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL en_flush_nostart got=%0b exp=0", seen); else pass_cnt++;
    total_cnt++; if (quotient !== 32'h0) $display("FAIL en_flush_quot got=%h exp=00000000", quotient); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_stall_hold();
    test_flush();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
